decode_issue_stage: RTL and testbench

Registered, parametrised successor to the processor's combinational decode control. Decodes one 32-bit instruction per cycle into the control bundle for execute. Holds it in a decode/execute pipeline register with a valid/ready handshake. Owns a scoreboard of destination registers pending from multi-cycle mul/div operations, and stalls dependent instructions until the mul/div unit reports completion. Sits between the fetch/F-D register and the execute stage; regfile read addresses are also driven combinationally from it.

---
 rtl/decode_issue_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_issue_stage.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes one instruction per cycle into the execute
// control bundle and holds it in a valid/ready decode-execute register.
// A scoreboard of mul/div destinations stalls dependent instructions until
// the mul/div unit reports completion.
module decode_issue_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_DEPTH   = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 in_instr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [REG_ADDR_W-1:0]       ctrl_readRegA,
    output logic [REG_ADDR_W-1:0]       ctrl_readRegB,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instr,
    output logic [REG_ADDR_W-1:0]       out_writeReg,
    output logic [REG_ADDR_W-1:0]       out_readRegA,
    output logic [REG_ADDR_W-1:0]       out_readRegB,
    output logic                        out_writeEnable,
    output logic                        out_choose_im,
    output logic                        out_sw,
    output logic                        out_lw,
    output logic                        out_is_md,
    input  logic                        md_done,
    input  logic [REG_ADDR_W-1:0]       md_done_reg,
    output logic [(1<<REG_ADDR_W)-1:0]  busy_mask
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int CNT_W    = $clog2(NUM_REGS) + 1;
    localparam logic [REG_ADDR_W-1:0] RA_REG     = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [REG_ADDR_W-1:0] STATUS_REG = REG_ADDR_W'(NUM_REGS - 2);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    logic [4:0]            opcode;
    logic [4:0]            aluop;
    logic [REG_ADDR_W-1:0] rd_f, rs_f, rt_f;
    logic is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_setx, is_bex;
    logic dec_is_md, dec_we, dec_im, chk_b;
    logic [REG_ADDR_W-1:0] dec_ra, dec_rb, dec_wr;

    logic haz_a, haz_b, haz_waw, md_full, stall, accept;
    logic set_en, kill_en, done_en;
    logic [CNT_W-1:0]    md_count, count_next;
    logic [NUM_REGS-1:0] busy_next;

    // Instruction field extraction and control decode for the incoming word.
    always_comb begin
        opcode  = in_instr[31:27];
        aluop   = in_instr[6:2];
        rd_f    = in_instr[22 +: REG_ADDR_W];
        rs_f    = in_instr[17 +: REG_ADDR_W];
        rt_f    = in_instr[12 +: REG_ADDR_W];

        is_j    = (opcode == OP_J);
        is_bne  = (opcode == OP_BNE);
        is_jal  = (opcode == OP_JAL);
        is_jr   = (opcode == OP_JR);
        is_addi = (opcode == OP_ADDI);
        is_blt  = (opcode == OP_BLT);
        is_sw   = (opcode == OP_SW);
        is_lw   = (opcode == OP_LW);
        is_setx = (opcode == OP_SETX);
        is_bex  = (opcode == OP_BEX);
        dec_is_md = (opcode == OP_R) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));

        dec_ra = is_bex ? STATUS_REG : rs_f;
        if (is_addi || is_bex)
            dec_rb = '0;
        else if (is_sw || is_jr || is_bne || is_blt)
            dec_rb = rd_f;
        else
            dec_rb = rt_f;
        dec_wr = is_setx ? STATUS_REG : (is_jal ? RA_REG : rd_f);

        dec_we = ~(is_sw | is_j | is_bne | is_jr | is_blt | is_bex | dec_is_md);
        dec_im = is_addi | is_sw | is_lw;
        chk_b  = ~(is_addi | is_bex);
    end

    assign ctrl_readRegA = dec_ra;
    assign ctrl_readRegB = dec_rb;

    // Hazard detection against the registered scoreboard only; md_done is
    // deliberately not bypassed so a dependent issues the cycle after completion.
    always_comb begin
        haz_a   = (dec_ra != '0) && busy_mask[dec_ra];
        haz_b   = chk_b && (dec_rb != '0) && busy_mask[dec_rb];
        haz_waw = (dec_we || dec_is_md) && (dec_wr != '0) && busy_mask[dec_wr];
        md_full = dec_is_md && (md_count == CNT_W'(MD_DEPTH));
        stall   = in_valid && (haz_a || haz_b || haz_waw || md_full);
        in_ready = ~reset & ~flush & ~stall & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
    end

    // Scoreboard next state: issue sets, flush of an unissued mul/div and
    // completion clear; a completion aimed at the killed entry is not double-counted.
    always_comb begin
        set_en  = accept && dec_is_md && (dec_wr != '0);
        kill_en = flush && out_valid && out_is_md && (out_writeReg != '0);
        done_en = md_done && (md_done_reg != '0) && busy_mask[md_done_reg]
                  && !(kill_en && (md_done_reg == out_writeReg));
        busy_next = busy_mask;
        if (set_en)  busy_next[dec_wr]       = 1'b1;
        if (kill_en) busy_next[out_writeReg] = 1'b0;
        if (done_en) busy_next[md_done_reg]  = 1'b0;
        count_next = md_count + CNT_W'(set_en) - CNT_W'(kill_en) - CNT_W'(done_en);
    end

    // Decode/execute register and scoreboard state.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_instr       <= '0;
            out_writeReg    <= '0;
            out_readRegA    <= '0;
            out_readRegB    <= '0;
            out_writeEnable <= 1'b0;
            out_choose_im   <= 1'b0;
            out_sw          <= 1'b0;
            out_lw          <= 1'b0;
            out_is_md       <= 1'b0;
            busy_mask       <= '0;
            md_count        <= '0;
        end else begin
            busy_mask <= busy_next;
            md_count  <= count_next;
            if (accept) begin
                out_valid       <= 1'b1;
                out_instr       <= in_instr;
                out_writeReg    <= dec_wr;
                out_readRegA    <= dec_ra;
                out_readRegB    <= dec_rb;
                out_writeEnable <= dec_we;
                out_choose_im   <= dec_im;
                out_sw          <= is_sw;
                out_lw          <= is_lw;
                out_is_md       <= dec_is_md;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: a behavioural model checked
// every cycle on the MD_DEPTH=1 instance, directed literal checks on both
// instances, and a second MD_DEPTH=2 instance for outstanding-count cases.
module tb_decode_issue_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  wr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        we;
        logic        im;
        logic        sw;
        logic        lw;
        logic        md;
    } dec_t;

    typedef struct packed {
        logic        v;
        dec_t        q;
        logic [31:0] busy;
        logic [5:0]  cnt;
    } mst_t;

    localparam int MDD = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [4:0]  ctrl_readRegA, ctrl_readRegB;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [4:0]  out_writeReg, out_readRegA, out_readRegB;
    logic        out_writeEnable, out_choose_im, out_sw, out_lw, out_is_md;
    logic        md_done = 1'b0;
    logic [4:0]  md_done_reg = '0;
    logic [31:0] busy_mask;

    logic [31:0] b_in_instr = '0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic        b_flush = 1'b0;
    logic [4:0]  b_ctrl_readRegA, b_ctrl_readRegB;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [31:0] b_out_instr;
    logic [4:0]  b_out_writeReg, b_out_readRegA, b_out_readRegB;
    logic        b_out_writeEnable, b_out_choose_im, b_out_sw, b_out_lw, b_out_is_md;
    logic        b_md_done = 1'b0;
    logic [4:0]  b_md_done_reg = '0;
    logic [31:0] b_busy_mask;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic chk_en = 1'b0;
    logic cap_en = 1'b0;
    mst_t ms;
    dec_t cap[$];

    decode_issue_stage #(.REG_ADDR_W(5), .MD_DEPTH(1)) dut (
        .clock(clock), .reset(reset), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_writeReg(out_writeReg), .out_readRegA(out_readRegA),
        .out_readRegB(out_readRegB), .out_writeEnable(out_writeEnable),
        .out_choose_im(out_choose_im), .out_sw(out_sw), .out_lw(out_lw),
        .out_is_md(out_is_md), .md_done(md_done), .md_done_reg(md_done_reg),
        .busy_mask(busy_mask)
    );

    decode_issue_stage #(.REG_ADDR_W(5), .MD_DEPTH(2)) dut2 (
        .clock(clock), .reset(reset), .in_instr(b_in_instr), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .ctrl_readRegA(b_ctrl_readRegA),
        .ctrl_readRegB(b_ctrl_readRegB), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_instr(b_out_instr), .out_writeReg(b_out_writeReg), .out_readRegA(b_out_readRegA),
        .out_readRegB(b_out_readRegB), .out_writeEnable(b_out_writeEnable),
        .out_choose_im(b_out_choose_im), .out_sw(b_out_sw), .out_lw(b_out_lw),
        .out_is_md(b_out_is_md), .md_done(b_md_done), .md_done_reg(b_md_done_reg),
        .busy_mask(b_busy_mask)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Instruction encoders.
    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [4:0] op, input logic [26:0] tgt);
        return {op, tgt};
    endfunction

    // Reference decode, written directly from the opcode table.
    function automatic dec_t dec(input logic [31:0] i);
        dec_t d;
        logic [4:0] op, rd, rs, rt, al;
        logic md;
        op = i[31:27]; rd = i[26:22]; rs = i[21:17]; rt = i[16:12]; al = i[6:2];
        md = (op == 5'd0) && (al == 5'd6 || al == 5'd7);
        d.instr = i;
        d.ra = (op == 5'd22) ? 5'd30 : rs;
        if (op inside {5'd5, 5'd22})                   d.rb = 5'd0;
        else if (op inside {5'd7, 5'd4, 5'd2, 5'd6})   d.rb = rd;
        else                                           d.rb = rt;
        d.wr = (op == 5'd21) ? 5'd30 : ((op == 5'd3) ? 5'd31 : rd);
        d.we = !((op inside {5'd7, 5'd1, 5'd2, 5'd4, 5'd6, 5'd22}) || md);
        d.im = op inside {5'd5, 5'd7, 5'd8};
        d.sw = (op == 5'd7);
        d.lw = (op == 5'd8);
        d.md = md;
        return d;
    endfunction

    function automatic logic ready_f(input mst_t s);
        dec_t d;
        logic hz;
        d = dec(in_instr);
        hz = 1'b0;
        if (d.ra != 0 && s.busy[d.ra]) hz = 1'b1;
        if (!(d.instr[31:27] inside {5'd5, 5'd22}) && d.rb != 0 && s.busy[d.rb]) hz = 1'b1;
        if ((d.we || d.md) && d.wr != 0 && s.busy[d.wr]) hz = 1'b1;
        if (d.md && s.cnt == 6'(MDD)) hz = 1'b1;
        return !reset && !flush && !(in_valid && hz) && (!s.v || out_ready);
    endfunction

    function automatic mst_t step(input mst_t s);
        mst_t n;
        dec_t d;
        logic acc;
        if (reset) return '0;
        n = s;
        d = dec(in_instr);
        acc = in_valid && ready_f(s);
        if (flush && s.v && s.q.md && s.q.wr != 0) begin
            n.busy[s.q.wr] = 1'b0;
            n.cnt = n.cnt - 6'd1;
        end
        if (md_done && md_done_reg != 0 && n.busy[md_done_reg]) begin
            n.busy[md_done_reg] = 1'b0;
            n.cnt = n.cnt - 6'd1;
        end
        if (acc) begin
            n.q = d;
            n.v = 1'b1;
            if (d.md && d.wr != 0) begin
                n.busy[d.wr] = 1'b1;
                n.cnt = n.cnt + 6'd1;
            end
        end else if (flush || out_ready) begin
            n.v = 1'b0;
        end
        return n;
    endfunction

    // Model state advances on each rising edge from the stimulus alone.
    always @(posedge clock) ms <= step(ms);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic dec_t dut_bundle();
        return {out_instr, out_writeReg, out_readRegA, out_readRegB,
                out_writeEnable, out_choose_im, out_sw, out_lw, out_is_md};
    endfunction

    // Per-cycle comparison of the MD_DEPTH=1 instance against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(ready_f(ms)));
            chk("readRegA", 64'(ctrl_readRegA), 64'(dec(in_instr).ra));
            chk("readRegB", 64'(ctrl_readRegB), 64'(dec(in_instr).rb));
            chk("out_valid", 64'(out_valid), 64'(ms.v));
            chk("busy_mask", 64'(busy_mask), 64'(ms.busy));
            chk("out_bundle", 64'(dut_bundle()), 64'(ms.q));
        end
        if (cap_en && out_valid && out_ready) cap.push_back(dut_bundle());
    end

    task automatic issue(input logic [31:0] ins);
        logic rdy;
        in_instr = ins;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            if (rdy) begin
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL issue_timeout: instr %0h never accepted", ins);
        in_valid = 1'b0;
    endtask

    task automatic md_pulse(input logic [4:0] r);
        md_done = 1'b1;
        md_done_reg = r;
        @(posedge clock);
        #1;
        md_done = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream[11];
        logic [31:0] ia, ib;
        int c0;

        stream[0]  = r_ins(5'd3, 5'd1, 5'd2, 5'd0);          // add r3,r1,r2
        stream[1]  = i_ins(5'd5, 5'd4, 5'd1, 17'd5);          // addi r4,r1,5
        stream[2]  = i_ins(5'd7, 5'd6, 5'd7, 17'd8);          // sw r6,8(r7)
        stream[3]  = i_ins(5'd8, 5'd8, 5'd9, 17'd4);          // lw r8,4(r9)
        stream[4]  = j_ins(5'd3, 27'd100);                    // jal
        stream[5]  = j_ins(5'd21, 27'd7);                     // setx
        stream[6]  = j_ins(5'd22, 27'd50);                    // bex
        stream[7]  = i_ins(5'd2, 5'd3, 5'd4, 17'd2);          // bne r3,r4
        stream[8]  = i_ins(5'd4, 5'd31, 5'd0, 17'd0);         // jr r31
        stream[9]  = i_ins(5'd6, 5'd5, 5'd6, 17'd3);          // blt r5,r6
        stream[10] = j_ins(5'd1, 27'd20);                     // j

        // Reset
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(negedge clock);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy_mask), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Full-throughput stream of non-md instructions
        cap_en = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 11; k++) issue(stream[k]);
        chk("stream_cycles", 64'(cyc - c0), 64'd11);
        @(negedge clock);
        @(posedge clock);
        #1;
        cap_en = 1'b0;
        chk("stream_outputs", 64'(cap.size()), 64'd11);
        if (cap.size() == 11) begin
            chk("add_wr_ra_rb", {cap[0].wr, cap[0].ra, cap[0].rb, cap[0].we, cap[0].im},
                {5'd3, 5'd1, 5'd2, 1'b1, 1'b0});
            chk("addi_im_rb", {cap[1].im, cap[1].rb, cap[1].we}, {1'b1, 5'd0, 1'b1});
            chk("sw_rb_we", {cap[2].rb, cap[2].we, cap[2].sw, cap[2].ra}, {5'd6, 1'b0, 1'b1, 5'd7});
            chk("lw_ctrl", {cap[3].lw, cap[3].im, cap[3].we, cap[3].wr}, {1'b1, 1'b1, 1'b1, 5'd8});
            chk("jal_wr_we", {cap[4].wr, cap[4].we}, {5'd31, 1'b1});
            chk("setx_wr_we", {cap[5].wr, cap[5].we}, {5'd30, 1'b1});
            chk("bex_ra_rb_we", {cap[6].ra, cap[6].rb, cap[6].we}, {5'd30, 5'd0, 1'b0});
            chk("bne_rb", {cap[7].rb, cap[7].ra, cap[7].we}, {5'd3, 5'd4, 1'b0});
            chk("jr_rb", {cap[8].rb, cap[8].we}, {5'd31, 1'b0});
            chk("blt_rb", {cap[9].rb, cap[9].we}, {5'd5, 1'b0});
            chk("j_we", 64'(cap[10].we), 64'd0);
        end

        // RAW stall on a mul result, released the cycle after md_done
        issue(r_ins(5'd5, 5'd1, 5'd2, 5'd6));
        ia = r_ins(5'd6, 5'd5, 5'd3, 5'd0);
        in_instr = ia;
        in_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("add_held", 64'(in_ready), 64'd0);
        chk("busy_r5", 64'(busy_mask[5]), 64'd1);
        @(posedge clock);
        #1;
        md_done = 1'b1;
        md_done_reg = 5'd5;
        @(negedge clock);
        chk("no_bypass", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        md_done = 1'b0;
        @(negedge clock);
        chk("add_after_done", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("add_issued", 64'(out_instr), 64'(ia));

        // MD_DEPTH=1: independent div waits for the outstanding mul
        @(posedge clock);
        #1;
        issue(r_ins(5'd5, 5'd1, 5'd2, 5'd6));
        in_instr = r_ins(5'd7, 5'd1, 5'd2, 5'd7);
        in_valid = 1'b1;
        @(negedge clock);
        chk("div_md_full", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        md_pulse(5'd5);
        @(negedge clock);
        chk("div_after_done", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        md_pulse(5'd7);

        // Flush of an unissued mul in the output register
        out_ready = 1'b0;
        issue(r_ins(5'd9, 5'd1, 5'd2, 5'd6));
        @(negedge clock);
        chk("mul9_held", {out_valid, busy_mask}, {1'b1, 32'h0000_0200});
        @(posedge clock);
        #1;
        flush = 1'b1;
        in_instr = r_ins(5'd1, 5'd2, 5'd3, 5'd0);
        in_valid = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("flush_cleared", {out_valid, busy_mask}, 64'd0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        in_instr = r_ins(5'd10, 5'd1, 5'd2, 5'd6);
        in_valid = 1'b1;
        @(negedge clock);
        chk("count_zero_after_flush", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        md_pulse(5'd10);

        // Backpressure hold and release
        out_ready = 1'b0;
        ia = r_ins(5'd1, 5'd2, 5'd3, 5'd0);
        ib = r_ins(5'd4, 5'd5, 5'd6, 5'd0);
        issue(ia);
        in_instr = ib;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("hold_out", {out_valid, in_ready, out_instr}, {1'b1, 1'b0, ia});
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("release_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("release_next", 64'(out_instr), 64'(ib));
        @(posedge clock);
        #1;

        // Spurious md_done for non-busy r4 and r0
        issue(r_ins(5'd8, 5'd1, 5'd2, 5'd6));
        md_pulse(5'd4);
        md_pulse(5'd0);
        in_instr = r_ins(5'd11, 5'd1, 5'd2, 5'd7);
        in_valid = 1'b1;
        @(negedge clock);
        chk("spurious_busy", 64'(busy_mask), 64'h0000_0100);
        chk("spurious_count", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        md_pulse(5'd8);

        // mul r0 sets nothing and does not occupy the single slot
        issue(r_ins(5'd0, 5'd1, 5'd2, 5'd6));
        in_instr = r_ins(5'd3, 5'd1, 5'd2, 5'd6);
        in_valid = 1'b1;
        @(negedge clock);
        chk("mul_r0_busy", 64'(busy_mask), 64'd0);
        chk("mul_r0_count", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        md_pulse(5'd3);

        // Reset mid-operation discards the pending entry and scoreboard
        out_ready = 1'b0;
        issue(r_ins(5'd12, 5'd1, 5'd2, 5'd6));
        reset = 1'b1;
        @(negedge clock);
        chk("reset_mid_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("reset_mid_state", {out_valid, busy_mask, out_instr}, 64'd0);
        @(posedge clock);
        #1;

        // MD_DEPTH=2 instance: back-to-back md ops, count limit, same-cycle set/clear
        b_in_instr = r_ins(5'd5, 5'd1, 5'd2, 5'd6);
        b_in_valid = 1'b1;
        @(negedge clock);
        chk("b_mul5_ready", 64'(b_in_ready), 64'd1);
        @(posedge clock);
        #1;
        b_in_instr = r_ins(5'd7, 5'd3, 5'd4, 5'd7);
        @(negedge clock);
        chk("b_div7_b2b", 64'(b_in_ready), 64'd1);
        @(posedge clock);
        #1;
        b_in_instr = r_ins(5'd9, 5'd1, 5'd2, 5'd6);
        @(negedge clock);
        chk("b_depth_full", 64'(b_in_ready), 64'd0);
        chk("b_busy_5_7", 64'(b_busy_mask), 64'h0000_00A0);
        chk("b_out_div7", {b_out_valid, b_out_instr, b_out_writeReg, b_out_readRegA, b_out_readRegB,
                           b_out_writeEnable, b_out_choose_im, b_out_sw, b_out_lw, b_out_is_md},
            {1'b1, r_ins(5'd7, 5'd3, 5'd4, 5'd7), 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("b_ctrl_rd", {b_ctrl_readRegA, b_ctrl_readRegB}, {5'd1, 5'd2});
        @(posedge clock);
        #1;
        b_md_done = 1'b1;
        b_md_done_reg = 5'd5;
        @(negedge clock);
        chk("b_no_bypass", 64'(b_in_ready), 64'd0);
        @(posedge clock);
        #1;
        b_md_done_reg = 5'd7;
        @(negedge clock);
        chk("b_mul9_ready", 64'(b_in_ready), 64'd1);
        @(posedge clock);
        #1;
        b_md_done = 1'b0;
        b_in_instr = r_ins(5'd11, 5'd1, 5'd2, 5'd7);
        @(negedge clock);
        chk("b_busy_9", 64'(b_busy_mask), 64'h0000_0200);
        chk("b_count_net", 64'(b_in_ready), 64'd1);
        @(posedge clock);
        #1;
        b_in_instr = r_ins(5'd13, 5'd1, 5'd2, 5'd6);
        @(negedge clock);
        chk("b_full_again", 64'(b_in_ready), 64'd0);
        chk("b_busy_9_11", 64'(b_busy_mask), 64'h0000_0A00);
        @(posedge clock);
        #1;
        b_in_valid = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
